// File: rtl/game_pkg.sv
// Shared playfield constants and coordinate types for the game datapath blocks.
// Screen-space coordinates are 12-bit unsigned throughout.
package game_pkg;

  localparam int COORD_W  = 12;
  localparam int D_WIDTH  = 640;
  localparam int D_HEIGHT = 480;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic {
    LAUNCH_READY,
    LAUNCH_COOLING
  } launch_state_e;

endpackage

// File: rtl/bullet_slot.sv
// One bullet slot: IDLE/FLYING flag plus centre position. Moves up by SPEED per
// frame tick and retires at the top edge or on a collision hit.
module bullet_slot
  import game_pkg::*;
#(
  parameter int B_SIZE = 4,
  parameter int SPEED  = 2
) (
  input  logic   i_clk,
  input  logic   i_rst,
  input  logic   i_tick,
  input  logic   i_spawn,
  input  coord_t i_spawn_x,
  input  coord_t i_spawn_y,
  input  logic   i_hit,
  output logic   o_active,
  output coord_t o_bx,
  output coord_t o_by
);

  localparam coord_t RETIRE_Y = coord_t'(B_SIZE + SPEED);
  localparam coord_t STEP     = coord_t'(SPEED);

  logic   active_q, active_d;
  coord_t bx_q, bx_d;
  coord_t by_q, by_d;

  always_comb begin
    // NOTE: every output of this block is defaulted before any branch, so no
    // path leaves a variable unassigned and no latch is inferred.
    active_d = active_q;
    bx_d     = bx_q;
    by_d     = by_q;

    if (i_spawn) begin
      active_d = 1'b1;
      bx_d     = i_spawn_x;
      by_d     = i_spawn_y;
    end else if (active_q) begin
      if (i_hit) begin
        active_d = 1'b0;
      end else if (i_tick) begin
        // Test against the pre-move position so the subtraction never wraps.
        if (by_q <= RETIRE_Y) begin
          active_d = 1'b0;
        end else begin
          by_d = by_q - STEP;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of statement order.
    if (i_rst) begin
      active_q <= 1'b0;
      bx_q     <= '0;
      by_q     <= '0;
    end else begin
      active_q <= active_d;
      bx_q     <= bx_d;
      by_q     <= by_d;
    end
  end

  assign o_active = active_q;
  assign o_bx     = bx_q;
  assign o_by     = by_q;

endmodule

// File: rtl/bullet_pool_ctrl.sv
// Player bullet scheduler: allocates the lowest free slot on a frame tick when
// fire is requested, rate-limited by a frame-counted cooldown.
module bullet_pool_ctrl
  import game_pkg::*;
#(
  parameter int N_SLOTS  = 4,
  parameter int B_SIZE   = 4,
  parameter int SPEED    = 2,
  parameter int COOLDOWN = 16,
  parameter int SHIP_H   = 80
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_ani_stb,
  input  logic                       i_animate,
  input  logic                       i_fire,
  input  logic [COORD_W-1:0]         i_ship_x,
  input  logic [COORD_W-1:0]         i_ship_y,
  input  logic [N_SLOTS-1:0]         i_hit,
  output logic [N_SLOTS-1:0]         o_active,
  output logic [COORD_W*N_SLOTS-1:0] o_bx,
  output logic [COORD_W*N_SLOTS-1:0] o_by,
  output logic                       o_fire_ack,
  output logic                       o_cooling
);

  localparam int            CD_W        = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam logic [CD_W-1:0] CD_RELOAD = CD_W'(COOLDOWN - 1);
  localparam coord_t        MIN_SPAWN_Y = coord_t'(SHIP_H + 2 * B_SIZE + 1);
  localparam coord_t        SPAWN_OFS   = coord_t'(SHIP_H + B_SIZE);

  logic               tick;
  logic [N_SLOTS-1:0] grant;
  logic               any_idle;
  logic               spawn;
  logic [N_SLOTS-1:0] spawn_vec;
  coord_t             spawn_y;

  launch_state_e   state_q, state_d;
  logic [CD_W-1:0] cd_q, cd_d;
  logic            ack_q, ack_d;
  logic            cooling_q, cooling_d;

  assign tick = i_animate & i_ani_stb;

  // Lowest-index slot that is IDLE before this edge; a slot retiring on the
  // same tick still reads active here and is therefore not eligible.
  always_comb begin
    grant    = '0;
    any_idle = 1'b0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (!o_active[i] && !any_idle) begin
        grant[i] = 1'b1;
        any_idle = 1'b1;
      end
    end
  end

  assign spawn     = tick && i_fire && (state_q == LAUNCH_READY) && any_idle &&
                     (i_ship_y >= MIN_SPAWN_Y);
  assign spawn_vec = spawn ? grant : '0;
  assign spawn_y   = i_ship_y - SPAWN_OFS;

  always_comb begin
    state_d   = state_q;
    cd_d      = cd_q;
    ack_d     = spawn;
    unique case (state_q)
      LAUNCH_READY: begin
        if (spawn) begin
          cd_d = CD_RELOAD;
          if (CD_RELOAD != '0) state_d = LAUNCH_COOLING;
        end
      end
      LAUNCH_COOLING: begin
        if (tick) begin
          cd_d = cd_q - CD_W'(1);
          if (cd_q == CD_W'(1)) state_d = LAUNCH_READY;
        end
      end
      default: state_d = LAUNCH_READY;
    endcase
    cooling_d = (state_d == LAUNCH_COOLING);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= LAUNCH_READY;
      cd_q      <= '0;
      ack_q     <= 1'b0;
      cooling_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cd_q      <= cd_d;
      ack_q     <= ack_d;
      cooling_q <= cooling_d;
    end
  end

  assign o_fire_ack = ack_q;
  assign o_cooling  = cooling_q;

  for (genvar k = 0; k < N_SLOTS; k++) begin : g_slot
    bullet_slot #(
      .B_SIZE (B_SIZE),
      .SPEED  (SPEED)
    ) u_slot (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_tick    (tick),
      .i_spawn   (spawn_vec[k]),
      .i_spawn_x (i_ship_x),
      .i_spawn_y (spawn_y),
      .i_hit     (i_hit[k]),
      .o_active  (o_active[k]),
      .o_bx      (o_bx[COORD_W*k +: COORD_W]),
      .o_by      (o_by[COORD_W*k +: COORD_W])
    );
  end

endmodule
